mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-ported memory between fetch and data stages (macro MEM_ARB_PERF_EN adds wait counters).
// Latency: request to *_valid is 3 cycles minimum (grant, mem_en, mem_ready), plus any extra memory wait cycles.
// Backpressure: requests are held until *_valid; *_stall is high while a request waits; data wins over fetch.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    input  logic              hlt,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_if_wait,
    output logic [15:0]       perf_dm_wait
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t state;
    logic   halt_q;
    logic   dm_pend;
    logic   if_pend;
    logic   dm_gnt;
    logic   if_gnt;
    logic   go_halt;

    // A requester whose valid is showing still holds its request; masking it avoids a reissue.
    assign dm_pend = dm_req & ~dm_valid;
    assign if_pend = if_req & ~if_valid;

    assign dm_gnt  = ((state == IDLE) & ~hlt & dm_pend) | ((state == HALT) & dm_pend);
    assign if_gnt  = (state == IDLE) & ~hlt & if_pend & ~dm_pend;
    assign go_halt = halt_q | hlt;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            halt_q    <= 1'b0;
            halted    <= 1'b0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_rdata  <= '0;
            dm_valid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            mem_en   <= 1'b0;
            if (hlt) begin
                halt_q <= 1'b1;
            end
            case (state)
                IDLE, HALT: begin
                    if ((state == IDLE) && hlt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (dm_gnt) begin
                        state     <= DM_BUSY;
                        halted    <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_wr    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_gnt) begin
                        state     <= IF_BUSY;
                        mem_en    <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                DM_BUSY: begin
                    if (mem_ready) begin
                        dm_valid <= 1'b1;
                        if (!mem_wr) begin
                            dm_rdata <= mem_rdata;
                        end
                        state  <= go_halt ? HALT : IDLE;
                        halted <= go_halt;
                    end
                end
                IF_BUSY: begin
                    if (mem_ready) begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                        state    <= go_halt ? HALT : IDLE;
                        halted   <= go_halt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_wait <= 16'h0000;
            perf_dm_wait <= 16'h0000;
        end else begin
            if (if_stall && (perf_if_wait != 16'hFFFF)) begin
                perf_if_wait <= perf_if_wait + 16'h0001;
            end
            if (dm_stall && (perf_dm_wait != 16'hFFFF)) begin
                perf_dm_wait <= perf_dm_wait + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-driven memory responses and hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        hlt;
    logic        halted;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_if_wait;
    logic [15:0] perf_dm_wait;
`endif

    int checks = 0;
    int errors = 0;
    int en_total = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_stall  (dm_stall),
        .hlt       (hlt),
        .halted    (halted),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_wait (perf_if_wait),
        .perf_dm_wait (perf_dm_wait)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_en === 1'b1) en_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the memory: answers one cycle after mem_en, returns when the selected valid shows.
    task automatic serve(input logic [15:0] rd, input bit is_dm, output int lat, output int ens, output bit ok);
        bit armed;
        lat   = 0;
        ens   = 0;
        ok    = 1'b0;
        armed = mem_en;
        for (int i = 0; i < 12; i++) begin
            tick();
            lat++;
            mem_ready = 1'b0;
            if (is_dm ? dm_valid : if_valid) begin
                ok = 1'b1;
                break;
            end
            if (armed) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
                armed     = 1'b0;
            end
            if (mem_en) begin
                ens++;
                armed = 1'b1;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int ens;
        bit ok;
        int snap;

        rst = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; hlt = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) tick();
        check("rst_mem_en", mem_en, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b1;
        tick();

        // Fetch only
        if_req = 1'b1; if_addr = 16'h0010;
        serve(16'hB123, 1'b0, lat, ens, ok);
        check("f_ok", ok, 1);
        check("f_latency", lat, 3);
        check("f_mem_en_cnt", ens, 1);
        check("f_rdata", if_rdata, 16'hB123);
        check("f_addr", mem_addr, 16'h0010);
        check("f_wr", mem_wr, 0);
        check("f_stall_at_valid", if_stall, 0);
        tick();
        check("f_no_regrant", mem_en, 0);
        check("f_valid_1cyc", if_valid, 0);
        if_req = 1'b0;
        tick();

        // Simultaneous fetch and load: data first
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
        tick();
        check("b_mem_en", mem_en, 1);
        check("b_dm_first", mem_addr, 16'h0200);
        check("b_if_stall", if_stall, 1);
        check("b_dm_stall", dm_stall, 1);
        serve(16'h00FF, 1'b1, lat, ens, ok);
        check("b_dm_ok", ok, 1);
        check("b_dm_rdata", dm_rdata, 16'h00FF);
        check("b_dm_stall_valid", dm_stall, 0);
        check("b_if_stall_valid", if_stall, 1);
        tick();
        check("b_if_grant_en", mem_en, 1);
        check("b_if_grant_addr", mem_addr, 16'h0020);
        check("b_if_grant_wr", mem_wr, 0);
        check("b_if_stall_late", if_stall, 1);
        dm_req = 1'b0;
        serve(16'h1234, 1'b0, lat, ens, ok);
        check("b_if_ok", ok, 1);
        check("b_if_rdata", if_rdata, 16'h1234);
        tick();
        if_req = 1'b0;
        tick();

        // Store
        snap = en_total;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0300; dm_wdata = 16'hCAFE;
        tick();
        check("s_mem_en", mem_en, 1);
        check("s_mem_wr", mem_wr, 1);
        check("s_mem_wdata", mem_wdata, 16'hCAFE);
        check("s_mem_addr", mem_addr, 16'h0300);
        serve(16'hDEAD, 1'b1, lat, ens, ok);
        check("s_ok", ok, 1);
        check("s_rdata_kept", dm_rdata, 16'h00FF);
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        check("s_single_en", en_total - snap, 1);

        // Halt during a fetch
        if_req = 1'b1; if_addr = 16'h0040;
        tick();
        check("h_mem_en", mem_en, 1);
        hlt = 1'b1;
        tick();
        hlt = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ready = 1'b0;
        check("h_if_valid", if_valid, 1);
        check("h_if_rdata", if_rdata, 16'h5555);
        check("h_halted", halted, 1);
        snap = en_total;
        repeat (5) tick();
        check("h_no_fetch_grant", en_total - snap, 0);
        check("h_still_halted", halted, 1);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0500;
        serve(16'h0A0A, 1'b1, lat, ens, ok);
        check("h_dm_ok", ok, 1);
        check("h_dm_rdata", dm_rdata, 16'h0A0A);
        check("h_back_to_halt", halted, 1);
        tick();
        dm_req = 1'b0; if_req = 1'b0;
        tick();

        // Reset in the middle of a data access, then a stale mem_ready
        rst = 1'b0;
        #1;
        check("r_halted_clear", halted, 0);
        rst = 1'b1;
        tick();
        dm_req = 1'b1; dm_addr = 16'h0600;
        tick();
        check("r_mem_en", mem_en, 1);
        tick();
        rst = 1'b0;
        #1;
        check("r_mem_en_low", mem_en, 0);
        check("r_mem_addr_low", mem_addr, 0);
        check("r_dm_rdata_low", dm_rdata, 0);
        check("r_dm_valid_low", dm_valid, 0);
        dm_req = 1'b0;
        #2;
        rst = 1'b1;
        mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        check("r_late_no_valid", dm_valid, 0);
        check("r_late_rdata", dm_rdata, 0);
        tick();
        check("r_late_no_valid2", dm_valid, 0);
        check("r_idle_no_en", mem_en, 0);

`ifdef MEM_ARB_PERF_EN
        check("p_if_zero", perf_if_wait, 0);
        if_req = 1'b1; if_addr = 16'h0070;
        repeat (5) tick();
        check("p_if_five", perf_if_wait, 5);
        dm_req = 1'b1;
        repeat (70000) tick();
        check("p_if_sat", perf_if_wait, 16'hFFFF);
        check("p_dm_sat", perf_dm_wait, 16'hFFFF);
        if_req = 1'b0; dm_req = 1'b0;
        rst = 1'b0;
        #1;
        check("p_rst_clear", perf_if_wait, 0);
        rst = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
